// File: rtl/class_clock_scheduler.sv
// Game clock, professor interruption and quiz deadline scheduler for the classroom game.
// Optional PROF_JITTER_EN: an LFSR randomises every professor countdown reload.
module class_clock_scheduler #(
  parameter int unsigned TICKS_PER_MIN = 100_000_000,
  parameter int unsigned PROF_PERIOD   = 16,
  parameter int unsigned QUIZ_WINDOW   = 10,
  parameter int unsigned MAX_TIME      = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       clear,
  input  logic       pause,
  input  logic       prof_ack,
  input  logic       quiz_done,
  output logic [7:0] minutes,
  output logic       min_tick,
  output logic       prof_req,
  output logic       quiz_timeout,
  output logic       time_up,
  output logic       running
);

  localparam int unsigned       PRE_W     = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_MIN - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [8:0]        PROF_BASE = 9'(PROF_PERIOD);
  localparam logic [8:0]        QUIZ_ADD  = (QUIZ_WINDOW > 255) ? 9'd255 : 9'(QUIZ_WINDOW);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_PROF_PENDING,
    ST_QUIZ_ACTIVE,
    ST_EXPIRED
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] prescale_reg, prescale_next;
  logic [7:0]       minutes_reg, minutes_next;
  logic             min_tick_reg, min_tick_next;
  logic [8:0]       prof_cnt_reg, prof_cnt_next;
  logic [8:0]       prof_reload;
  logic [7:0]       deadline_reg, deadline_next;
  logic [8:0]       deadline_sum;
  logic             prof_req_reg, prof_req_next;
  logic             quiz_timeout_reg, quiz_timeout_next;
  logic             time_up_reg, time_up_next;
  logic             running_reg, running_next;

  logic at_max;
  logic deadline_hit;
  logic advance;
  logic wrap;
  logic reload_prof;
  logic take_ack;
  logic timeout_hit;

  assign at_max       = ({24'd0, minutes_reg} >= MAX_TIME);
  assign deadline_hit = (minutes_reg >= deadline_reg);
  assign deadline_sum = {1'b0, minutes_reg} + QUIZ_ADD;
  assign advance      = running_reg && !pause;
  assign wrap         = advance && (prescale_reg == PRE_LAST);

`ifdef PROF_JITTER_EN
  // Galois form of x^8+x^6+x^5+x^4+1; shifts right, feedback from bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;
  logic [9:0] jitter_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lfsr
      if (gi == 7) begin : g_top
        assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
      end else begin : g_mid
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
      end
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign jitter_sum  = {1'b0, PROF_BASE} + {7'd0, lfsr_reg[2:0]};
  assign prof_reload = (jitter_sum <= 10'd4) ? 9'd1 : 9'(jitter_sum - 10'd4);
`else
  assign prof_reload = (PROF_BASE == 9'd0) ? 9'd1 : PROF_BASE;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_STOPPED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    reload_prof = 1'b0;
    take_ack    = 1'b0;
    timeout_hit = 1'b0;
    if (clear) begin
      state_next = ST_STOPPED;
    end else begin
      case (state_reg)
        ST_STOPPED: begin
          if (start) begin
            state_next  = ST_RUNNING;
            reload_prof = 1'b1;
          end
        end
        ST_RUNNING: begin
          if (at_max) begin
            state_next = ST_EXPIRED;
          end else if (min_tick_reg && (prof_cnt_reg == 9'd1)) begin
            state_next = ST_PROF_PENDING;
          end
        end
        ST_PROF_PENDING: begin
          if (prof_ack) begin
            state_next = ST_QUIZ_ACTIVE;
            take_ack   = 1'b1;
          end else if (at_max) begin
            state_next = ST_EXPIRED;
          end
        end
        // End of class is deliberately not checked while a quiz is open.
        ST_QUIZ_ACTIVE: begin
          if (quiz_done) begin
            state_next  = ST_RUNNING;
            reload_prof = 1'b1;
          end else if (deadline_hit) begin
            state_next  = ST_RUNNING;
            reload_prof = 1'b1;
            timeout_hit = 1'b1;
          end
        end
        ST_EXPIRED: begin
          state_next = ST_EXPIRED;
        end
        default: begin
          state_next = ST_STOPPED;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    prof_req_next     = (state_next == ST_PROF_PENDING);
    time_up_next      = (state_next == ST_EXPIRED);
    running_next      = (state_next == ST_RUNNING) ||
                        (state_next == ST_PROF_PENDING) ||
                        (state_next == ST_QUIZ_ACTIVE);
    quiz_timeout_next = timeout_hit;
  end

  always_comb begin
    prescale_next = prescale_reg;
    minutes_next  = minutes_reg;
    min_tick_next = 1'b0;
    prof_cnt_next = prof_cnt_reg;
    deadline_next = deadline_reg;
    if (clear) begin
      prescale_next = '0;
      minutes_next  = 8'd0;
      prof_cnt_next = 9'd0;
      deadline_next = 8'd0;
    end else begin
      if (wrap) begin
        prescale_next = '0;
        min_tick_next = 1'b1;
        if (minutes_reg != 8'hFF) begin
          minutes_next = minutes_reg + 8'd1;
        end
      end else if (advance) begin
        prescale_next = prescale_reg + PRE_ONE;
      end

      if (reload_prof) begin
        prof_cnt_next = prof_reload;
      end else if ((state_reg == ST_RUNNING) && min_tick_reg && (prof_cnt_reg != 9'd0)) begin
        prof_cnt_next = prof_cnt_reg - 9'd1;
      end

      if (take_ack) begin
        deadline_next = deadline_sum[8] ? 8'hFF : deadline_sum[7:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescale_reg <= '0;
      minutes_reg  <= 8'd0;
      min_tick_reg <= 1'b0;
      prof_cnt_reg <= PROF_BASE;
      deadline_reg <= 8'd0;
    end else begin
      prescale_reg <= prescale_next;
      minutes_reg  <= minutes_next;
      min_tick_reg <= min_tick_next;
      prof_cnt_reg <= prof_cnt_next;
      deadline_reg <= deadline_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prof_req_reg     <= 1'b0;
      quiz_timeout_reg <= 1'b0;
      time_up_reg      <= 1'b0;
      running_reg      <= 1'b0;
    end else begin
      prof_req_reg     <= prof_req_next;
      quiz_timeout_reg <= quiz_timeout_next;
      time_up_reg      <= time_up_next;
      running_reg      <= running_next;
    end
  end

  assign minutes      = minutes_reg;
  assign min_tick     = min_tick_reg;
  assign prof_req     = prof_req_reg;
  assign quiz_timeout = quiz_timeout_reg;
  assign time_up      = time_up_reg;
  assign running      = running_reg;

endmodule

// File: tb/tb_class_clock_scheduler.sv
// Directed bench for class_clock_scheduler with a minute/event-level reference model
// compared against the DUT on every falling clock edge.
module tb_class_clock_scheduler;

  localparam int T    = 4;
  localparam int P    = 3;
  localparam int QW   = 2;
  localparam int MAXT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, pause, prof_ack, quiz_done;
  logic [7:0] minutes;
  logic       min_tick, prof_req, quiz_timeout, time_up, running;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  class_clock_scheduler #(
    .TICKS_PER_MIN(T),
    .PROF_PERIOD  (P),
    .QUIZ_WINDOW  (QW),
    .MAX_TIME     (MAXT)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .start       (start),
    .clear       (clear),
    .pause       (pause),
    .prof_ack    (prof_ack),
    .quiz_done   (quiz_done),
    .minutes     (minutes),
    .min_tick    (min_tick),
    .prof_req    (prof_req),
    .quiz_timeout(quiz_timeout),
    .time_up     (time_up),
    .running     (running)
  );

  // Reference model: the phase is carried by the visible levels themselves
  // (running / waiting for the professor / in a quiz / over); the professor
  // visit is scheduled as an absolute minute rather than a countdown.
  int m_minutes = 0;
  int m_acc     = 0;
  int m_prof_at = 0;
  int m_deadline = 0;
  bit m_tick = 0, m_req = 0, m_to = 0, m_up = 0, m_run = 0, m_in_quiz = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_minutes <= 0; m_acc <= 0; m_prof_at <= P; m_deadline <= 0;
      m_tick <= 0; m_req <= 0; m_to <= 0; m_up <= 0; m_run <= 0; m_in_quiz <= 0;
    end else if (clear) begin
      m_minutes <= 0; m_acc <= 0; m_deadline <= 0;
      m_tick <= 0; m_req <= 0; m_to <= 0; m_up <= 0; m_run <= 0; m_in_quiz <= 0;
    end else begin
      if (m_run && !pause) begin
        if (m_acc == T - 1) begin
          m_acc     <= 0;
          m_minutes <= (m_minutes < 255) ? m_minutes + 1 : 255;
          m_tick    <= 1;
        end else begin
          m_acc  <= m_acc + 1;
          m_tick <= 0;
        end
      end else begin
        m_tick <= 0;
      end
      m_to <= 0;
      if (!m_run && !m_up) begin
        if (start) begin
          m_run     <= 1;
          m_prof_at <= m_minutes + P;
        end
      end else if (m_req) begin
        if (prof_ack) begin
          m_req      <= 0;
          m_in_quiz  <= 1;
          m_deadline <= (m_minutes + QW > 255) ? 255 : m_minutes + QW;
        end else if (m_minutes >= MAXT) begin
          m_req <= 0; m_run <= 0; m_up <= 1;
        end
      end else if (m_in_quiz) begin
        if (quiz_done || m_minutes >= m_deadline) begin
          m_in_quiz <= 0;
          m_to      <= !quiz_done;
          m_prof_at <= m_minutes + P;
        end
      end else if (m_run) begin
        if (m_minutes >= MAXT) begin
          m_run <= 0; m_up <= 1;
        end else if (m_tick && m_minutes == m_prof_at) begin
          m_req <= 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_minutes", minutes, m_minutes);
    chk("model_min_tick", min_tick, m_tick);
    chk("model_prof_req", prof_req, m_req);
    chk("model_quiz_timeout", quiz_timeout, m_to);
    chk("model_time_up", time_up, m_up);
    chk("model_running", running, m_run);
  end

  function automatic bit sig(input int sel);
    case (sel)
      0:       return min_tick;
      1:       return prof_req;
      2:       return quiz_timeout;
      default: return time_up;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(sel) && n < budget);
    if (!sig(sel)) begin
      total++;
      bad++;
      $display("FAIL %s: signal still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; clear = 0; pause = 0; prof_ack = 0; quiz_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ack_cycle();
    prof_ack = 1'b1;
    @(negedge clk);
    prof_ack = 1'b0;
  endtask

  task automatic quick_prof();
    int n;
    wait_sig("quick_req", 1, 40, n);
    ack_cycle();
    quiz_done = 1'b1;
    @(negedge clk);
    quiz_done = 1'b0;
  endtask

  initial begin
    int n;
    int seen;

    do_reset();
    chk("reset_minutes", minutes, 0);
    chk("reset_running", running, 0);
    chk("reset_prof_req", prof_req, 0);
    chk("reset_time_up", time_up, 0);
    $display("reset: minutes=%0d running=%0d", minutes, running);

    // Start, tick spacing, pause freeze and resume.
    pulse_start();
    chk("start_running", running, 1);
    wait_sig("tick1", 0, 20, n);
    chk("tick1_gap", n, 4);
    chk("tick1_minutes", minutes, 1);
    wait_sig("tick2", 0, 20, n);
    chk("tick2_gap", n, 4);
    chk("tick2_minutes", minutes, 2);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    chk("pause_hold", minutes, 2);
    pause = 1'b0;
    wait_sig("tick3", 0, 30, n);
    chk("resume_gap", n, 4);
    chk("tick3_minutes", minutes, 3);
    $display("start/pause: minutes=%0d", minutes);

    // Professor at minute 3, ack, answered at minute 4, next visit at 7.
    wait_sig("req1", 1, 5, n);
    chk("req1_lag", n, 1);
    chk("req1_minutes", minutes, 3);
    ack_cycle();
    chk("req1_drop", prof_req, 0);
    wait_sig("tick4", 0, 10, n);
    chk("tick4_minutes", minutes, 4);
    quiz_done = 1'b1;
    @(negedge clk);
    quiz_done = 0;
    wait_sig("req2", 1, 60, n);
    chk("req2_minutes", minutes, 7);
    $display("quiz answered: next prof_req at minutes=%0d", minutes);

    // Unanswered quiz: timeout one cycle after minutes reaches 5.
    do_reset();
    pulse_start();
    wait_sig("req_to", 1, 40, n);
    chk("req_to_minutes", minutes, 3);
    ack_cycle();
    wait_sig("timeout", 2, 40, n);
    chk("timeout_lag", n, 7);
    chk("timeout_minutes", minutes, 5);
    @(negedge clk);
    chk("timeout_one_cycle", quiz_timeout, 0);
    chk("timeout_back_running", running, 1);
    $display("quiz timeout: minutes=%0d", minutes);

    // quiz_done on the deadline cycle suppresses the timeout.
    do_reset();
    pulse_start();
    wait_sig("req_dl", 1, 40, n);
    ack_cycle();
    wait_sig("tick4_dl", 0, 10, n);
    wait_sig("tick5_dl", 0, 10, n);
    chk("deadline_minutes", minutes, 5);
    quiz_done = 1'b1;
    @(negedge clk);
    quiz_done = 1'b0;
    seen = 0;
    repeat (12) begin
      if (quiz_timeout) seen++;
      @(negedge clk);
    end
    chk("done_beats_deadline", seen, 0);
    chk("done_running", running, 1);
    $display("done on deadline: timeouts=%0d", seen);

    // Run to end of class with the professor left waiting, then clear.
    wait_sig("expire", 3, 200, n);
    chk("expire_minutes", minutes, 10);
    chk("expire_running", running, 0);
    chk("expire_prof_req", prof_req, 0);
    repeat (12) @(negedge clk);
    chk("expired_hold_minutes", minutes, 10);
    chk("expired_hold_time_up", time_up, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_minutes", minutes, 0);
    chk("clear_time_up", time_up, 0);
    chk("clear_running", running, 0);
    chk("clear_prof_req", prof_req, 0);
    chk("clear_min_tick", min_tick, 0);
    chk("clear_timeout", quiz_timeout, 0);
    pulse_start();
    chk("restart_running", running, 1);
    $display("expire/clear: minutes=%0d running=%0d", minutes, running);

    // Quiz straddling MAX_TIME: expiry only after returning to RUNNING.
    do_reset();
    pulse_start();
    quick_prof();
    quick_prof();
    wait_sig("req9", 1, 40, n);
    chk("req9_minutes", minutes, 9);
    ack_cycle();
    wait_sig("tick10", 0, 10, n);
    chk("quiz_minutes10", minutes, 10);
    chk("quiz_no_time_up", time_up, 0);
    @(negedge clk);
    chk("quiz_still_no_time_up", time_up, 0);
    quiz_done = 1'b1;
    @(negedge clk);
    quiz_done = 1'b0;
    chk("returned_running", running, 1);
    chk("returned_no_time_up", time_up, 0);
    @(negedge clk);
    chk("late_time_up", time_up, 1);
    chk("late_running", running, 0);
    $display("quiz across end: time_up=%0d", time_up);

    // Asynchronous reset while the professor is waiting.
    do_reset();
    pulse_start();
    wait_sig("req_async", 1, 40, n);
    #2;
    rst = 1'b1;
    #1;
    chk("async_prof_req", prof_req, 0);
    chk("async_running", running, 0);
    chk("async_minutes", minutes, 0);
    do_reset();
    $display("async reset: prof_req=%0d", prof_req);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/class_clock_scheduler.md
# class_clock_scheduler

Game-time and interruption scheduler for the classroom game. It owns the in-game clock: a prescaled `minutes` count and the periodic "professor" interruption. It runs the request/acknowledge handshake with the game state machine, tracks the quiz answer deadline, and flags end of class. It sits between the board clock and the game FSM and replaces free-running minute logic and combinational professor decoding.

## Interface
Parameters:
- `TICKS_PER_MIN`, default 100_000_000: Clk cycles per game minute.
- `PROF_PERIOD`, default 16: game minutes between professor visits (1..255).
- `QUIZ_WINDOW`, default 10: game minutes allowed to answer a quiz.
- `MAX_TIME`, default 120: minute count that ends the class.

Ports:
- `Clk`, in, 1: clock.
- `Reset`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: begin the class clock (sampled only in STOPPED).
- `clear`, in, 1: synchronous return to STOPPED; zeroes all counters.
- `pause`, in, 1: freezes the prescaler while high.
- `prof_ack`, in, 1: game FSM has entered its quiz.
- `quiz_done`, in, 1: one-cycle pulse, quiz answered (right or wrong).
- `minutes`, out, 8: elapsed game minutes; saturates at 255.
- `min_tick`, out, 1: one-cycle pulse on each minute increment.
- `prof_req`, out, 1: professor interruption request (level).
- `quiz_timeout`, out, 1: one-cycle pulse, quiz deadline missed.
- `time_up`, out, 1: level, class over.
- `running`, out, 1: high in every state except STOPPED and EXPIRED.

## Operation
- Reset values: `minutes`=0, `min_tick`=0, `prof_req`=0, `quiz_timeout`=0, `time_up`=0, `running`=0. State is STOPPED, prescaler=0, `prof_cnt`=PROF_PERIOD.
- Prescaler counts 0..TICKS_PER_MIN-1. It advances only when `running` is high and `pause` is low. On wrap it increments `minutes` (held at 255) and pulses `min_tick`.
- States:
  - STOPPED: when `start` is high, go to RUNNING and reload `prof_cnt`.
  - RUNNING: `prof_cnt` decrements on each `min_tick`. A `min_tick` with `prof_cnt`==1 goes to PROF_PENDING. When `minutes` >= MAX_TIME, go to EXPIRED; this has priority over PROF_PENDING.
  - PROF_PENDING: `prof_req`=1 and the clock keeps running. `prof_ack` goes to QUIZ_ACTIVE and latches `deadline` = min(`minutes`+QUIZ_WINDOW, 255), computed 9-bit then saturated. When `minutes` >= MAX_TIME with no ack, go to EXPIRED.
  - QUIZ_ACTIVE: `prof_req`=0. MAX_TIME is ignored here (no forced loss mid-quiz). `quiz_done` goes to RUNNING. `minutes` >= `deadline` pulses `quiz_timeout` and goes to RUNNING. Either exit reloads `prof_cnt`.
  - EXPIRED: `time_up`=1 and the prescaler is frozen. Only `clear` exits.
- Priority: `clear` > Reset-free transitions. If `quiz_done` and the deadline occur in the same cycle, `quiz_done` wins and no timeout pulse is produced.
- Returning to RUNNING with `minutes` >= MAX_TIME expires on the next cycle.

## Timing
- All outputs are registered.
- `min_tick` and the `minutes` update occur in the same cycle, one Clk after the prescaler terminal count.
- `prof_req` rises one cycle after the triggering `min_tick`. It stays high until the cycle after `prof_ack` is sampled.
- `prof_ack` is ignored outside PROF_PENDING. `quiz_done` is ignored outside QUIZ_ACTIVE.
- `quiz_timeout` is asserted one cycle after `minutes` reaches `deadline`.
- `clear` takes effect at the next edge. All outputs read their reset values one cycle later.
- Asynchronous Reset mid-quiz drops `prof_req` immediately and discards `deadline`.

## Configuration
- `PROF_JITTER_EN`: when defined, an 8-bit Galois LFSR (taps 8,6,5,4; seed 8'hA5 on Reset) advances every Clk. Every `prof_cnt` reload then uses PROF_PERIOD + `lfsr[2:0]` − 4, clamped to a minimum of 1.
- Not defined: every reload uses exactly PROF_PERIOD and no LFSR is built.

## Test plan
Bench parameters for all scenarios: TICKS_PER_MIN=4, PROF_PERIOD=3, QUIZ_WINDOW=2, MAX_TIME=10, macro undefined.
- Reset, then `start` pulse: `min_tick` every 4 cycles; `minutes` steps 0→1→2→3.
- Hold `pause` for 10 cycles while RUNNING: `minutes` and the prescaler are frozen, then resume from the same count.
- At `minutes`=3: `prof_req`=1 and is held until `prof_ack`. Ack at `minutes`=3, then `quiz_done` at `minutes`=4: `prof_req`=0, no `quiz_timeout`, next `prof_req` at `minutes`=7.
- Ack at `minutes`=3, no `quiz_done`: one `quiz_timeout` pulse when `minutes`=5, returns to RUNNING. Same test with `quiz_done` on the deadline cycle: no pulse.
- Run to `minutes`=10 outside a quiz: `time_up`=1, `running`=0, `minutes` stays 10. Then `clear`: all outputs 0, state STOPPED.
- Ack at `minutes`=9 (QUIZ_ACTIVE through 10): `time_up` stays 0 until `quiz_done`, then `time_up`=1 one cycle after returning to RUNNING.
